mem_sweep_reader: RTL and testbench

Clocked read sequencer for the neuron/weight memory port. A single command (base address, word count) is expanded into a stream of read addresses toward the memory's read-address channel. Returned read data is collected in a 2-entry output buffer and forwarded downstream with a last-word marker. Wrap-around and back-pressure are handled on both sides. It sits between the PE/NoC packetiser (consumer) and the memory's read port, alongside the writer that drives the save-address and data channels.

---
 rtl/mem_sweep_reader.sv | 109 ++++++++++
 tb/tb_mem_sweep_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_reader.sv
// Read sequencer: expands (base, count) into a wrapping stream of read addresses and
// forwards the returned words through a 2-entry buffer, tagging the final word.
module mem_sweep_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_base,
    input  logic [WIDTH-1:0] cmd_count,
    output logic             rd_addr_valid,
    input  logic             rd_addr_ready,
    output logic [WIDTH-1:0] rd_addr,
    input  logic             rd_data_valid,
    output logic             rd_data_ready,
    input  logic [WIDTH-1:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [WIDTH-1:0] DEPTH_W   = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] addr, remaining;
    logic [1:0]       outstanding, buffered, out_nxt, buf_nxt;
    logic [WIDTH-1:0] fifo_data [2];
    logic [1:0]       fifo_last;
    logic             wr_ptr, rd_ptr, err_q;
    logic             cmd_hs, cmd_ok, addr_hs, rsp_hs, push, drop, pop, last_word;

    assign cmd_ready     = (state == IDLE) && !reset;
    assign rd_addr_valid = (state == ISSUE) && (({1'b0, outstanding} + {1'b0, buffered}) < 3'd2);
    assign rd_addr       = addr;
    assign rd_data_ready = !reset;
    assign out_valid     = (buffered != 2'd0);
    assign out_data      = fifo_data[rd_ptr];
    assign out_last      = out_valid && fifo_last[rd_ptr];
    assign busy          = (state != IDLE);
    assign err           = err_q;

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign cmd_ok  = cmd_hs && (cmd_base < DEPTH_W) && (cmd_count != '0);
    assign addr_hs = rd_addr_valid && rd_addr_ready;
    assign rsp_hs  = rd_data_valid && rd_data_ready;
    assign push    = rsp_hs && (outstanding != 2'd0);
    assign drop    = rsp_hs && (outstanding == 2'd0);
    assign pop     = out_valid && out_ready;
    assign out_nxt = outstanding + {1'b0, addr_hs} - {1'b0, push};
    assign buf_nxt = buffered + {1'b0, push} - {1'b0, pop};
    // Responses return in order and nothing is issued in DRAIN, so the one
    // arriving with a single request outstanding there is the final word.
    assign last_word = (state == DRAIN) && (outstanding == 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_ok) state_nxt = ISSUE;
            ISSUE:   if (addr_hs && remaining == WIDTH'(1)) state_nxt = DRAIN;
            DRAIN:   if (out_nxt == 2'd0 && buf_nxt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr         <= '0;
            remaining    <= '0;
            outstanding  <= 2'd0;
            buffered     <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            buffered    <= buf_nxt;
            if (cmd_hs && cmd_base >= DEPTH_W) err_q <= 1'b1;
            if (drop) err_q <= 1'b1;
            if (cmd_ok) begin
                addr      <= cmd_base;
                remaining <= cmd_count;
            end else if (addr_hs) begin
                addr      <= (addr == LAST_ADDR) ? '0 : addr + WIDTH'(1);
                remaining <= remaining - WIDTH'(1);
            end
            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= last_word;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end
endmodule

// File: tb/tb_mem_sweep_reader.sv
// Scoreboard bench: expected words/addresses are queued when a command is driven
// and compared as the reader issues addresses and emits words.
module tb_mem_sweep_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready;
    logic [WIDTH-1:0] cmd_base, cmd_count;
    logic             rd_addr_valid, rd_addr_ready;
    logic [WIDTH-1:0] rd_addr;
    logic             rd_data_valid, rd_data_ready;
    logic [WIDTH-1:0] rd_data;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last, busy, err;

    mem_sweep_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH] = '{8'h11, 8'h22, 8'h33};
    logic [WIDTH:0]   exp_q [$];   // {last, data}
    logic [WIDTH-1:0] exp_a [$];
    int               n_checks = 0, n_err = 0, n_issued = 0;
    logic             toggle_en = 1'b0;
    logic             a_stall = 1'b0, o_stall = 1'b0;
    logic [WIDTH-1:0] a_hold, o_hold;
    logic             o_last_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle-latency memory
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_data_valid <= rd_addr_valid && rd_addr_ready;
            rd_data       <= (rd_addr < WIDTH'(DEPTH)) ? mem[rd_addr] : '0;
        end
    end

    always @(posedge clk) if (toggle_en) #1 rd_addr_ready = ~rd_addr_ready;

    always @(negedge clk) begin
        if (reset) begin
            a_stall = 1'b0;
            o_stall = 1'b0;
        end else begin
            if (a_stall) begin
                chk("addr_hold", rd_addr, a_hold);
                chk("addr_valid_hold", rd_addr_valid, 1);
            end
            if (o_stall) begin
                chk("out_hold", {out_valid, out_last, out_data}, {1'b1, o_last_hold, o_hold});
            end
            a_stall = rd_addr_valid && !rd_addr_ready;
            a_hold  = rd_addr;
            o_stall = out_valid && !out_ready;
            o_hold  = out_data;
            o_last_hold = out_last;
            if (rd_addr_valid && rd_addr_ready) begin
                n_issued++;
                if (exp_a.size() != 0) chk("rd_addr", rd_addr, exp_a.pop_front());
                else chk("unexpected_addr", 1, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) chk("out_word", {out_last, out_data}, exp_q.pop_front());
                else chk("unexpected_out", 1, 0);
            end
        end
    end

    task automatic issue_cmd(input int base, input int count);
        int a;
        cmd_base  = WIDTH'(base);
        cmd_count = WIDTH'(count);
        cmd_valid = 1'b1;
        if (base < DEPTH) begin
            for (int i = 0; i < count; i++) begin
                a = (base + i) % DEPTH;
                exp_a.push_back(WIDTH'(a));
                exp_q.push_back({(i == count - 1), mem[a]});
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0;
        rd_addr_ready = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {cmd_ready, rd_addr_valid, rd_addr, rd_data_ready, out_valid, out_data, out_last, busy, err}, 0);
        reset = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        // wrap sweep
        issue_cmd(1, 4);
        chk("t1_busy", busy, 1);
        chk("t1_first_addr", {rd_addr_valid, rd_addr}, {1'b1, 8'd1});
        wait_done("t1");

        // count 0 no-op
        n_issued = 0;
        issue_cmd(0, 0);
        repeat (3) @(posedge clk); #1;
        chk("t2_idle", {busy, err, rd_addr_valid}, 0);
        chk("t2_issued", n_issued, 0);

        // out-of-range base
        issue_cmd(3, 2);
        repeat (3) @(posedge clk); #1;
        chk("t3_err", err, 1);
        chk("t3_issued", n_issued, 0);
        issue_cmd(0, 1);
        wait_done("t3b");
        chk("t3_err_sticky", err, 1);

        // downstream stall
        out_ready = 1'b0;
        n_issued = 0;
        issue_cmd(0, 3);
        repeat (10) @(posedge clk); #1;
        chk("t4_issued_le2", (n_issued <= 2), 1);
        chk("t4_no_credit", rd_addr_valid, 0);
        chk("t4_head", {out_valid, out_data}, {1'b1, 8'h11});
        out_ready = 1'b1;
        wait_done("t4");

        // rd_addr_ready toggling
        toggle_en = 1'b1;
        issue_cmd(0, 4);
        wait_done("t5");
        toggle_en = 1'b0;
        #2 rd_addr_ready = 1'b1;
        chk("t5_addrs_left", exp_a.size(), 0);

        // reset mid-command
        @(posedge clk); #1;
        issue_cmd(0, 3);
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_outputs", {cmd_ready, rd_addr_valid, rd_addr, rd_data_ready, out_valid, out_data, out_last, busy, err}, 0);
        exp_q.delete();
        exp_a.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t6_cmd_ready", cmd_ready, 1);
        issue_cmd(2, 2);
        wait_done("t6");
        chk("t6_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end
endmodule
